tmr_fault_manager: RTL and testbench

TMR_FAULT_MANAGER -- requirements
Module: tmr_fault_manager

---
 rtl/tmr_pkg.sv | 30 +++
 rtl/fault_tracker.sv | 60 ++++++
 rtl/tmr_fault_manager.sv | 122 ++++++++++++
 tb/tb_tmr_fault_manager.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tmr_pkg : shared FSM encoding, core indices and voter bit map for the TMR
//           fault manager.   Rev 1.0
// ---------------------------------------------------------------------------
package tmr_pkg;

  localparam int NUM_CORES = 3;

  typedef logic [1:0] core_idx_t;

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_RESYNC = 2'd1;
  localparam logic [1:0] ST_FAIL   = 2'd2;

  localparam core_idx_t CORE_A = 2'd0;
  localparam core_idx_t CORE_B = 2'd1;
  localparam core_idx_t CORE_C = 2'd2;

  localparam logic [2:0] VS_CORE_A   = 3'b001;
  localparam logic [2:0] VS_CORE_B   = 3'b010;
  localparam logic [2:0] VS_CORE_C   = 3'b100;
  localparam logic [2:0] NO_MAJORITY = 3'b111;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fault_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fault_tracker : per-core mismatch streak, saturating error counter and
//                 resync attempt count.   Rev 1.0
// ---------------------------------------------------------------------------
module fault_tracker
  import tmr_pkg::*;
#(
  parameter int STREAK_LIMIT = 3,
  parameter int MAX_RESYNC   = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             mismatch,
  input  logic             streak_clr,
  input  logic             resync_inc,
  output logic [CNT_W-1:0] err_cnt,
  output logic             candidate,
  output logic             exhausted
);

  localparam int SW = (STREAK_LIMIT < 1) ? 1 : $clog2(STREAK_LIMIT + 1);
  localparam int RW = (MAX_RESYNC < 1) ? 1 : $clog2(MAX_RESYNC + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STREAK_LIMIT);
  localparam logic [RW-1:0] RCNT_MAX   = RW'(MAX_RESYNC);

  logic [SW-1:0] streak;
  logic [SW-1:0] streak_nxt;
  logic [RW-1:0] rcnt;

  always_comb begin
    streak_nxt = streak;
    if (mismatch) begin
      if (streak != STREAK_MAX) streak_nxt = streak + 1'b1;
    end else if (valid) begin
      streak_nxt = '0;
    end
  end

  // Candidacy looks at the post-sample streak so the FSM reacts on the
  // detection edge itself.
  assign candidate = (streak_nxt == STREAK_MAX);
  assign exhausted = (rcnt == RCNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak  <= '0;
      err_cnt <= '0;
      rcnt    <= '0;
    end else begin
      streak <= streak_clr ? '0 : streak_nxt;
      if (mismatch && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
      if (resync_inc && (rcnt != RCNT_MAX)) rcnt <= rcnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tmr_fault_manager.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tmr_fault_manager : TMR voter supervision - streak-based fault detection,
//                     resync arbitration, core exclusion and halt.   Rev 1.0
// ---------------------------------------------------------------------------
module tmr_fault_manager
  import tmr_pkg::*;
#(
  parameter int STREAK_LIMIT = 3,
  parameter int MAX_RESYNC   = 2,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         voter_state,
  input  logic               voter_valid,
  input  logic               resync_ack,
  output logic               resync_req,
  output logic [1:0]         resync_core,
  output logic [2:0]         core_disable,
  output logic               halt,
  output logic [3*CNT_W-1:0] err_cnt,
  output logic [1:0]         fsm_state
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       req_nxt;
  logic [1:0] core_nxt;
  logic [2:0] dis_nxt;

  logic [2:0] mismatch;
  logic [2:0] cand;
  logic [2:0] cand_eff;
  logic [2:0] sel_oh;
  logic [1:0] sel_idx;
  logic [2:0] exhausted;
  logic [2:0] streak_clr;
  logic [2:0] resync_inc;
  logic       fail_now;

  assign mismatch = {3{voter_valid}} & voter_state & ~core_disable;

  generate
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
      fault_tracker #(
        .STREAK_LIMIT (STREAK_LIMIT),
        .MAX_RESYNC   (MAX_RESYNC),
        .CNT_W        (CNT_W)
      ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .valid      (voter_valid),
        .mismatch   (mismatch[i]),
        .streak_clr (streak_clr[i]),
        .resync_inc (resync_inc[i]),
        .err_cnt    (err_cnt[i*CNT_W +: CNT_W]),
        .candidate  (cand[i]),
        .exhausted  (exhausted[i])
      );
    end
  endgenerate

  // Lowest-index candidate wins; remaining candidates are picked up later.
  assign cand_eff = cand & ~core_disable;
  assign sel_oh   = cand_eff & (~cand_eff + 3'd1);
  assign sel_idx  = sel_oh[0] ? CORE_A : (sel_oh[1] ? CORE_B : CORE_C);

  assign fail_now = (voter_valid && (voter_state == NO_MAJORITY)) ||
                    (popcount3(core_disable) >= 2'd2);

  always_comb begin
    state_nxt  = state;
    req_nxt    = resync_req;
    core_nxt   = resync_core;
    dis_nxt    = core_disable;
    streak_clr = '0;
    resync_inc = '0;
    if (state != ST_FAIL) begin
      if (fail_now) begin
        state_nxt = ST_FAIL;
        req_nxt   = 1'b0;
      end else if (state == ST_RESYNC) begin
        if (resync_ack) begin
          streak_clr = 3'b001 << resync_core;
          req_nxt    = 1'b0;
          state_nxt  = ST_NORMAL;
        end
      end else if (|sel_oh) begin
        if (|(sel_oh & exhausted)) begin
          dis_nxt    = core_disable | sel_oh;
          streak_clr = sel_oh;
        end else begin
          resync_inc = sel_oh;
          req_nxt    = 1'b1;
          core_nxt   = sel_idx;
          state_nxt  = ST_RESYNC;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_NORMAL;
      resync_req   <= 1'b0;
      resync_core  <= CORE_A;
      core_disable <= '0;
      halt         <= 1'b0;
    end else begin
      state        <= state_nxt;
      resync_req   <= req_nxt;
      resync_core  <= core_nxt;
      core_disable <= dis_nxt;
      halt         <= (state_nxt == ST_FAIL);
    end
  end

  assign fsm_state = state;

endmodule
`default_nettype wire

// File: tb/tb_tmr_fault_manager.sv
`default_nettype none
// Bench for tmr_fault_manager: directed vector table, corner sequences and
// randomized traffic against a behavioural reference model.
module tb_tmr_fault_manager;
  import tmr_pkg::*;

  localparam int SL = 3;
  localparam int MR = 2;
  localparam int CW = 8;
  localparam int ERR_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    voter_state = 3'b000;
  logic          voter_valid = 1'b0;
  logic          resync_ack = 1'b0;
  logic          resync_req;
  logic [1:0]    resync_core;
  logic [2:0]    core_disable;
  logic          halt;
  logic [3*CW-1:0] err_cnt;
  logic [1:0]    fsm_state;

  tmr_fault_manager #(.STREAK_LIMIT(SL), .MAX_RESYNC(MR), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .voter_state  (voter_state),
    .voter_valid  (voter_valid),
    .resync_ack   (resync_ack),
    .resync_req   (resync_req),
    .resync_core  (resync_core),
    .core_disable (core_disable),
    .halt         (halt),
    .err_cnt      (err_cnt),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: 0=NORMAL 1=RESYNC 2=FAIL
  int md_state, md_req, md_core, md_halt;
  int md_err[3], md_streak[3], md_rcnt[3], md_dis[3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int err_of(input int i);
    return int'(err_cnt[i*CW +: CW]);
  endfunction

  task automatic model_reset();
    md_state = 0; md_req = 0; md_core = 0; md_halt = 0;
    for (int i = 0; i < 3; i++) begin
      md_err[i] = 0; md_streak[i] = 0; md_rcnt[i] = 0; md_dis[i] = 0;
    end
  endtask

  task automatic model_step(input bit v, input bit [2:0] s, input bit a);
    int ndis;
    int sel;
    bit hit;
    ndis = md_dis[0] + md_dis[1] + md_dis[2];
    sel = -1;
    for (int i = 0; i < 3; i++) begin
      hit = v && s[i] && (md_dis[i] == 0);
      if (hit) begin
        if (md_err[i] < ERR_MAX) md_err[i]++;
        if (md_streak[i] < SL) md_streak[i]++;
      end else if (v) begin
        md_streak[i] = 0;
      end
    end
    for (int i = 2; i >= 0; i--)
      if (md_streak[i] == SL && md_dis[i] == 0) sel = i;
    if (md_state == 2) begin
      // sticky
    end else if ((v && s == 3'b111) || ndis >= 2) begin
      md_state = 2; md_halt = 1; md_req = 0;
    end else if (md_state == 1) begin
      if (a) begin
        md_streak[md_core] = 0; md_req = 0; md_state = 0;
      end
    end else if (sel >= 0) begin
      if (md_rcnt[sel] < MR) begin
        md_rcnt[sel]++; md_state = 1; md_req = 1; md_core = sel;
      end else begin
        md_dis[sel] = 1; md_streak[sel] = 0;
      end
    end
  endtask

  task automatic check_model();
    chk("state", int'(fsm_state), md_state);
    chk("resync_req", int'(resync_req), md_req);
    if (md_req == 1) chk("resync_core", int'(resync_core), md_core);
    chk("halt", int'(halt), md_halt);
    chk("core_disable", int'(core_disable), md_dis[0] + 2*md_dis[1] + 4*md_dis[2]);
    for (int i = 0; i < 3; i++) chk($sformatf("err_cnt[%0d]", i), err_of(i), md_err[i]);
  endtask

  task automatic cycle(input bit v, input bit [2:0] s, input bit a);
    voter_valid = v; voter_state = s; resync_ack = a;
    @(posedge clk);
    model_step(v, s, a);
    #1;
    check_model();
  endtask

  task automatic do_reset(input bit hold_ack);
    #2;
    rst = 1'b0;
    voter_valid = 1'b0; voter_state = 3'b000; resync_ack = hold_ack;
    #1;
    chk("rst_req", int'(resync_req), 0);
    chk("rst_core", int'(resync_core), 0);
    chk("rst_dis", int'(core_disable), 0);
    chk("rst_halt", int'(halt), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_state", int'(fsm_state), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 3'b000, hold_ack);
  endtask

  typedef struct {
    bit       do_rst;
    bit       v;
    bit [2:0] s;
    bit       a;
    bit       req;
    bit [1:0] core;
    bit [1:0] st;
    bit [7:0] ea;
    bit [7:0] eb;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // basic resync on B, then ack two cycles later
    tbl.push_back('{1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 8'd1});
    tbl.push_back('{1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 8'd2});
    tbl.push_back('{1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 2'd1, 2'd1, 8'd0, 8'd3});
    tbl.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 2'd1, 8'd0, 8'd3});
    tbl.push_back('{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0, 8'd3});
    tbl.push_back('{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 8'd3});
    // broken streak on A never reaches the limit
    tbl.push_back('{1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0, 2'd0, 8'd1, 8'd0});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0, 2'd0, 8'd2, 8'd0});
    tbl.push_back('{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, 8'd2, 8'd0});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0, 2'd0, 8'd3, 8'd0});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0, 2'd0, 8'd4, 8'd0});
    // invalid gap holds the streak
    tbl.push_back('{1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0, 2'd0, 8'd1, 8'd0});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0, 2'd0, 8'd2, 8'd0});
    tbl.push_back('{1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 2'd0, 8'd2, 8'd0});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 2'd0, 2'd1, 8'd3, 8'd0});
    tbl.push_back('{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0, 8'd3, 8'd0});

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].do_rst) do_reset(1'b0);
      cycle(tbl[k].v, tbl[k].s, tbl[k].a);
      chk($sformatf("tbl%0d_req", k), int'(resync_req), int'(tbl[k].req));
      if (tbl[k].req) chk($sformatf("tbl%0d_core", k), int'(resync_core), int'(tbl[k].core));
      chk($sformatf("tbl%0d_state", k), int'(fsm_state), int'(tbl[k].st));
      chk($sformatf("tbl%0d_errA", k), err_of(0), int'(tbl[k].ea));
      chk($sformatf("tbl%0d_errB", k), err_of(1), int'(tbl[k].eb));
    end

    // core C exhausts its resyncs, then core B does -> second exclusion halts
    do_reset(1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 3; j++) cycle(1'b1, 3'b100, 1'b0);
      if (r < 2) cycle(1'b0, 3'b000, 1'b1);
    end
    chk("c_disable", int'(core_disable), 4);
    chk("c_no_req", int'(resync_req), 0);
    for (int j = 0; j < 4; j++) cycle(1'b1, 3'b100, 1'b0);
    chk("c_err_frozen", err_of(2), 9);
    chk("c_not_fail", int'(halt), 0);
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 3; j++) cycle(1'b1, 3'b010, 1'b0);
      if (r < 2) cycle(1'b0, 3'b000, 1'b1);
    end
    chk("bc_disable", int'(core_disable), 6);
    chk("bc_halt_lag", int'(halt), 0);
    cycle(1'b0, 3'b000, 1'b0);
    chk("bc_halt", int'(halt), 1);

    // no majority in NORMAL and in RESYNC
    do_reset(1'b0);
    cycle(1'b1, 3'b111, 1'b0);
    chk("nm_halt", int'(halt), 1);
    chk("nm_state", int'(fsm_state), 2);
    cycle(1'b0, 3'b000, 1'b1);
    chk("nm_sticky", int'(fsm_state), 2);
    do_reset(1'b0);
    for (int j = 0; j < 3; j++) cycle(1'b1, 3'b010, 1'b0);
    cycle(1'b1, 3'b111, 1'b0);
    chk("nmr_req", int'(resync_req), 0);
    chk("nmr_halt", int'(halt), 1);
    cycle(1'b0, 3'b000, 1'b1);
    chk("nmr_sticky", int'(fsm_state), 2);

    // 300 valid mismatches on A, long RESYNC with invalid gaps, saturation
    do_reset(1'b0);
    for (int j = 0; j < 3; j++) cycle(1'b1, 3'b001, 1'b0);
    for (int j = 0; j < 297; j++) begin
      if (j % 10 == 0) cycle(1'b0, 3'b001, 1'b0);
      cycle(1'b1, 3'b001, 1'b0);
    end
    cycle(1'b0, 3'b000, 1'b1);
    chk("sat_errA", err_of(0), 255);
    cycle(1'b1, 3'b001, 1'b0);
    cycle(1'b1, 3'b001, 1'b0);
    cycle(1'b0, 3'b000, 1'b0);
    cycle(1'b0, 3'b000, 1'b0);
    chk("gap_no_req", int'(resync_req), 0);
    cycle(1'b1, 3'b001, 1'b0);
    chk("gap_req", int'(resync_req), 1);

    // simultaneous A and B detection, then reset mid-RESYNC with ack held
    do_reset(1'b0);
    for (int j = 0; j < 3; j++) cycle(1'b1, 3'b011, 1'b0);
    chk("ab_core_a", int'(resync_core), 0);
    cycle(1'b0, 3'b000, 1'b0);
    cycle(1'b0, 3'b000, 1'b1);
    chk("ab_ret", int'(resync_req), 0);
    cycle(1'b0, 3'b000, 1'b0);
    chk("ab_req_b", int'(resync_req), 1);
    chk("ab_core_b", int'(resync_core), 1);
    do_reset(1'b1);
    chk("post_rst_req", int'(resync_req), 0);

    // randomized traffic
    do_reset(1'b0);
    for (int n = 0; n < 1500; n++) begin
      bit v, a;
      bit [2:0] s;
      int pick;
      if (n % 75 == 74) do_reset(1'b0);
      v = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 59);
      if (pick == 0) s = 3'b111;
      else if (pick < 20) s = 3'b000;
      else if (pick < 50) s = 3'b001 << (pick % 3);
      else s = 3'($urandom_range(0, 6));
      a = ($urandom_range(0, 2) == 0);
      cycle(v, s, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
